// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core control path: forwarding selects, result
// source codes and the MDU sequencing state machine.
// No ports; imported by the hazard controller and its forwarding compare.
package core_ctrl_pkg;

  // Execute-stage source mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW from writeback
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU_ResultM from memory

  // ResultSrc encoding that marks a load
  localparam logic [1:0] RESSRC_LOAD = 2'b01;

  // MUL/DIV sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/ex_hazard_controller_fwd_select.sv
// Forwarding compare for one execute source operand (combinational).
// Ports: rs_i source register; rd/reg_write for memory and writeback stages;
//        fwd_o mux select (memory stage wins over writeback, x0 never forwards).
module fwd_select
  import core_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard controller: operand forwarding, load-use stall,
// branch/jump flush and MUL/DIV sequencing (freeze F/D/E, bubble EX/MEM).
// Ports: decode/execute source regs, E/M/W dest regs and write enables,
//        ResultSrcE, PCSrcE, MulDivE in; forward selects, stalls, flushes,
//        MduStart/MduBusy out. Optional HAZARD_PERF_CNT_EN adds three
//        saturating 32-bit event counters (PerfLwStall, PerfMduStall, PerfFlush).
module ex_hazard_controller
  import core_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,  // total execute cycles of a MUL/DIV op, 2..32
  parameter int CNT_W       = 5   // 2**CNT_W must exceed MDU_LATENCY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] RD_E,
  input  logic [4:0] RD_M,
  input  logic [4:0] RD_W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulDivE,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MduStart,
  output logic       MduBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] PerfLwStall,
  output logic [31:0] PerfMduStall,
  output logic [31:0] PerfFlush
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lw_stall;
  logic             mdu_hold;

  fwd_select u_fwd_a (
    .rs_i          (Rs1_E),
    .rd_m_i        (RD_M),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RD_W),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardA_E)
  );

  fwd_select u_fwd_b (
    .rs_i          (Rs2_E),
    .rd_m_i        (RD_M),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RD_W),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardB_E)
  );

  assign lw_stall = (ResultSrcE == RESSRC_LOAD) && (RD_E != 5'd0) &&
                    ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // The op is held in execute for every cycle except the last (DONE).
  assign mdu_hold = MulDivE && ((state_q == IDLE) || (state_q == BUSY));
  assign MduStart = (state_q == IDLE) && MulDivE && !PCSrcE;
  assign MduBusy  = (state_q != IDLE);

  assign StallF = lw_stall | mdu_hold;
  assign StallD = lw_stall | mdu_hold;
  assign StallE = mdu_hold;
  assign FlushM = mdu_hold;
  assign FlushD = PCSrcE;
  // Execute is frozen during an MDU hold, so a pending load-use bubble waits.
  assign FlushE = PCSrcE | (lw_stall & !mdu_hold);

  // Counter holds the remaining execute cycles; DONE is entered when it
  // would reach 1. With MDU_LATENCY==2 the load value is already 1, so the
  // sequence goes straight to DONE to keep the latency exact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MduStart) begin
            cnt_q   <= CNT_LOAD;
            state_q <= (MDU_LATENCY == 2) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_TWO) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PerfLwStall  <= '0;
      PerfMduStall <= '0;
      PerfFlush    <= '0;
    end else begin
      if (lw_stall && !mdu_hold && (PerfLwStall != 32'hFFFF_FFFF)) begin
        PerfLwStall <= PerfLwStall + 32'd1;
      end
      if (mdu_hold && (PerfMduStall != 32'hFFFF_FFFF)) begin
        PerfMduStall <= PerfMduStall + 32'd1;
      end
      if (PCSrcE && (PerfFlush != 32'hFFFF_FFFF)) begin
        PerfFlush <= PerfFlush + 32'd1;
      end
    end
  end
`endif

endmodule
